// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the 7-segment scan driver.
// Segment order is a..g in bits 0..6, decimal point in bit 7.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_e;

    localparam int SEG_A_BIT  = 0;
    localparam int SEG_B_BIT  = 1;
    localparam int SEG_C_BIT  = 2;
    localparam int SEG_D_BIT  = 3;
    localparam int SEG_E_BIT  = 4;
    localparam int SEG_F_BIT  = 5;
    localparam int SEG_G_BIT  = 6;
    localparam int SEG_DP_BIT = 7;

    localparam logic [7:0] SEG_OFF = 8'h00;
    localparam logic [7:0] SEG_0   = 8'h3F;
    localparam logic [7:0] SEG_1   = 8'h06;
    localparam logic [7:0] SEG_2   = 8'h5B;
    localparam logic [7:0] SEG_3   = 8'h4F;
    localparam logic [7:0] SEG_4   = 8'h66;
    localparam logic [7:0] SEG_5   = 8'h6D;
    localparam logic [7:0] SEG_6   = 8'h7D;
    localparam logic [7:0] SEG_7   = 8'h07;
    localparam logic [7:0] SEG_8   = 8'h7F;
    localparam logic [7:0] SEG_9   = 8'h6F;
    localparam logic [7:0] SEG_A   = 8'h77;
    localparam logic [7:0] SEG_B   = 8'h7C;
    localparam logic [7:0] SEG_C   = 8'h39;
    localparam logic [7:0] SEG_D   = 8'h5E;
    localparam logic [7:0] SEG_E   = 8'h79;
    localparam logic [7:0] SEG_F   = 8'h71;

    // Glyph constants carry a cleared dp bit; strip it to get the a..g field.
    function automatic logic [6:0] glyph_bits(input logic [7:0] glyph);
        return glyph[SEG_G_BIT:SEG_A_BIT];
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display port between the processor core (master) and the scan driver (slave).
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp;
    logic [7:0]            seg;
    logic [DIGITS-1:0]     gate;
    logic                  frame_done;

    modport master (
        output en, value, dp,
        input  seg, gate, frame_done
    );

    modport slave (
        input  en, value, dp,
        output seg, gate, frame_done
    );
endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to a..g segment pattern (active-high).
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (nibble_i)
            4'h0:    seg_o = glyph_bits(SEG_0);
            4'h1:    seg_o = glyph_bits(SEG_1);
            4'h2:    seg_o = glyph_bits(SEG_2);
            4'h3:    seg_o = glyph_bits(SEG_3);
            4'h4:    seg_o = glyph_bits(SEG_4);
            4'h5:    seg_o = glyph_bits(SEG_5);
            4'h6:    seg_o = glyph_bits(SEG_6);
            4'h7:    seg_o = glyph_bits(SEG_7);
            4'h8:    seg_o = glyph_bits(SEG_8);
            4'h9:    seg_o = glyph_bits(SEG_9);
            4'hA:    seg_o = glyph_bits(SEG_A);
            4'hB:    seg_o = glyph_bits(SEG_B);
            4'hC:    seg_o = glyph_bits(SEG_C);
            4'hD:    seg_o = glyph_bits(SEG_D);
            4'hE:    seg_o = glyph_bits(SEG_E);
            default: seg_o = glyph_bits(SEG_F);
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner with per-slot blanking and frame-coherent snapshots.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading-zero digits.
module seg7_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_driver_if.slave bus
);
    import seg7_pkg::*;

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   val_q, val_d;
    logic [DIGITS-1:0]     dpsh_q, dpsh_d;
    logic [7:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     gate_q, gate_d;
    logic                  fd_q, fd_d;

    logic [6:0]            glyph [DIGITS];
    logic                  blank_digit;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : gen_dec
            seg7_hex_decoder u_dec (
                .nibble_i (val_q[4*gi +: 4]),
                .seg_o    (glyph[gi])
            );
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    // lz_zero[i]: nibble i and all more-significant nibbles are zero.
    logic [DIGITS-1:0] lz_zero;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : gen_lz
            assign lz_zero[gi] = (val_q[4*DIGITS-1:4*gi] == '0);
        end
    endgenerate
    assign blank_digit = lz_zero[idx_d] && (idx_d != '0);
`else
    assign blank_digit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = BLANK;
                BLANK:   if (cnt_q == BLANK_LAST) state_d = DRIVE;
                DRIVE:   if (cnt_q == CNT_LAST)   state_d = BLANK;
                default: state_d = IDLE;
            endcase
        end
    end

    // Slot counter spans the whole slot (blank + drive); shadows reload only at frame start.
    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        val_d  = val_q;
        dpsh_d = dpsh_q;
        if (!bus.en) begin
            cnt_d = '0;
            idx_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d  = '0;
                    idx_d  = '0;
                    val_d  = bus.value;
                    dpsh_d = bus.dp;
                end
                BLANK: cnt_d = cnt_q + CW'(1);
                DRIVE: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d  = '0;
                            val_d  = bus.value;
                            dpsh_d = bus.dp;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    cnt_d = '0;
                    idx_d = '0;
                end
            endcase
        end
    end

    // Outputs derive from next-state values so they register on the transition edge itself.
    always_comb begin
        seg_d  = SEG_OFF;
        gate_d = '0;
        fd_d   = 1'b0;
        if (state_d == DRIVE) begin
            gate_d = DIGITS'(1) << idx_d;
            seg_d[SEG_DP_BIT] = dpsh_q[idx_d];
            seg_d[SEG_G_BIT:SEG_A_BIT] = blank_digit ? 7'h00 : glyph[idx_d];
            fd_d = (idx_d == IDX_LAST) && (cnt_d == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            val_q  <= '0;
            dpsh_q <= '0;
            seg_q  <= SEG_OFF;
            gate_q <= '0;
            fd_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            val_q  <= val_d;
            dpsh_q <= dpsh_d;
            seg_q  <= seg_d;
            gate_q <= gate_d;
            fd_q   <= fd_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.gate       = gate_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a time-based display model feeds a queue
// that a negedge monitor drains; directed checks cover the documented scenarios.
module tb_seg7_scan_driver;

    localparam int D     = 4;
    localparam int P     = 8;
    localparam int B     = 2;
    localparam int FRAME = D * P;

    logic clk;
    logic rst;

    seg7_scan_driver_if #(.DIGITS(D)) bus ();

    seg7_scan_driver #(
        .DIGITS       (D),
        .PRESCALE     (P),
        .BLANK_CYCLES (B)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] glyph_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                   8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    typedef struct {
        int         at;
        logic [D-1:0] gate;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];

    // Reference: display is a pure function of cycles elapsed since the enabling edge.
    bit          m_on = 1'b0;
    int          m_t  = 0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_dp  = '0;

    always @(posedge clk) begin
        exp_t e;
        int slot, ph;
        logic [15:0] upper;
        if (rst || !bus.en) begin
            m_on = 1'b0;
        end else if (!m_on) begin
            m_on  = 1'b1;
            m_t   = 0;
            m_val = bus.value;
            m_dp  = bus.dp;
        end else begin
            m_t = m_t + 1;
            if (m_t % FRAME == 0) begin
                m_val = bus.value;
                m_dp  = bus.dp;
            end
        end
        e.at   = cyc + 1;
        e.gate = '0;
        e.seg  = 8'h00;
        e.fd   = 1'b0;
        if (m_on) begin
            slot = (m_t / P) % D;
            ph   = m_t % P;
            if (ph >= B) begin
                upper  = m_val >> (4 * slot);
                e.gate = D'(1 << slot);
                e.seg  = glyph_tab[upper[3:0]];
`ifdef LEADING_ZERO_BLANK_EN
                if (slot > 0 && upper == 16'h0) e.seg = 8'h00;
`endif
                e.seg[7] = m_dp[slot];
                e.fd = (slot == D - 1) && (ph == P - 1);
            end
        end
        exp_q.push_back(e);
    end

    // Monitor: the DUT presents gate/seg/frame_done every cycle; pop and compare each one.
    int printed = 0;
    always @(negedge clk) begin
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            if (printed < 30) $display("FAIL scoreboard_empty cyc=%0d", cyc);
            printed++;
        end else begin
            e = exp_q.pop_front();
            if (bus.gate !== e.gate || bus.seg !== e.seg || bus.frame_done !== e.fd) begin
                bad++;
                if (printed < 30)
                    $display("FAIL scoreboard cyc=%0d got gate=%b seg=%h fd=%b want gate=%b seg=%h fd=%b",
                             e.at, bus.gate, bus.seg, bus.frame_done, e.gate, e.seg, e.fd);
                printed++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end else begin
            $display("check %s ok value=%0h", nm, act);
        end
    endtask

    task automatic wait_gate(input logic [D-1:0] g, input logic [7:0] s, input string nm);
        int k = 0;
        while (bus.gate !== g && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            total++;
            bad++;
            $display("FAIL %s timeout waiting gate=%b", nm, g);
        end else begin
            chk(nm, 32'(bus.seg), 32'(s));
        end
    endtask

    task automatic wait_fd(output int at);
        int k = 0;
        at = -1;
        @(negedge clk);
        while (bus.frame_done !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            total++;
            bad++;
            $display("FAIL frame_done timeout");
        end else begin
            at = cyc;
        end
    endtask

    initial begin
        int t0, t1, k;
        rst       = 1'b1;
        bus.en    = 1'b0;
        bus.value = '0;
        bus.dp    = '0;
        repeat (3) @(negedge clk);
        chk("reset_gate", 32'(bus.gate), 32'h0);
        chk("reset_seg",  32'(bus.seg),  32'h0);
        chk("reset_fd",   32'(bus.frame_done), 32'h0);

        rst       = 1'b0;
        bus.en    = 1'b1;
        bus.value = 16'h12AF;
        bus.dp    = 4'b0100;
        wait_gate(4'b0001, 8'h71, "d0_F");
        wait_gate(4'b0010, 8'h77, "d1_A");
        wait_gate(4'b0100, 8'hDB, "d2_2dp");
        wait_gate(4'b1000, 8'h06, "d3_1");
        wait_fd(t0);
        wait_fd(t1);
        chk("frame_period", 32'(t1 - t0), 32'(FRAME));

        wait_gate(4'b0010, 8'h77, "pre_change_d1");
        bus.value = 16'h3333;
        bus.dp    = 4'b0000;
        wait_gate(4'b0100, 8'hDB, "coherent_d2");
        wait_gate(4'b1000, 8'h06, "coherent_d3");
        wait_gate(4'b0001, 8'h4F, "new_frame_d0");
        wait_gate(4'b0010, 8'h4F, "new_frame_d1");

        wait_gate(4'b0100, 8'h4F, "pre_disable_d2");
        bus.en = 1'b0;
        @(negedge clk);
        chk("disable_gate", 32'(bus.gate), 32'h0);
        chk("disable_seg",  32'(bus.seg),  32'h0);
        chk("disable_fd",   32'(bus.frame_done), 32'h0);
        bus.en = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.gate == '0 && k < 50);
        chk("reenable_latency", 32'(k), 32'(B + 1));
        chk("reenable_gate", 32'(bus.gate), 32'h1);

        wait_gate(4'b0100, 8'h4F, "pre_reset_d2");
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_gate", 32'(bus.gate), 32'h0);
        chk("midrst_seg",  32'(bus.seg),  32'h0);
        rst = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.gate == '0 && k < 50);
        chk("restart_gate", 32'(bus.gate), 32'h1);

        for (int i = 0; i < 40; i++) begin
            int r;
            @(negedge clk);
            r = $urandom_range(0, 7);
            if (r == 0) begin
                bus.en = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                bus.en = 1'b1;
            end else if (r == 1) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                bus.value = 16'($urandom);
                bus.dp    = 4'($urandom);
            end
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        bus.value = 16'h0050;
        bus.dp    = 4'b0000;
        wait_fd(t0);
        wait_gate(4'b0001, 8'h3F, "z50_d0");
        wait_gate(4'b0010, 8'h6D, "z50_d1");
`ifdef LEADING_ZERO_BLANK_EN
        wait_gate(4'b0100, 8'h00, "z50_d2");
        wait_gate(4'b1000, 8'h00, "z50_d3");
`else
        wait_gate(4'b0100, 8'h3F, "z50_d2");
        wait_gate(4'b1000, 8'h3F, "z50_d3");
`endif
        bus.value = 16'h0000;
        wait_fd(t0);
        wait_gate(4'b0001, 8'h3F, "z00_d0");
`ifdef LEADING_ZERO_BLANK_EN
        wait_gate(4'b0010, 8'h00, "z00_d1");
`else
        wait_gate(4'b0010, 8'h3F, "z00_d1");
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
